riscv_multicycle_datapath: RTL

Parametrised multicycle successor to the single-cycle add/sub/load/store datapath. Takes one RV64I-subset instruction at a time through a valid/ready port, decodes it internally and sequences it through an FSM with registered ALU result. Reaches data memory through an external req/ack port that tolerates wait states. Owns the register file, with x0 hardwired to zero. Sits between the fetch unit and the data-memory wrapper.

---
 rtl/riscv_multicycle_datapath_if.sv | 29 ++
 rtl/riscv_multicycle_datapath.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_datapath_if.sv
// Instruction and data-memory port bundle for riscv_multicycle_datapath.
// slave: the datapath; master: fetch unit / memory wrapper side.
interface riscv_multicycle_datapath_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DM_AW = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic              dm_req;
  logic              dm_we;
  logic [DM_AW-1:0]  dm_addr;
  logic [XLEN-1:0]   dm_wdata;
  logic [XLEN-1:0]   dm_rdata;
  logic              dm_ack;
  logic              retire;
  logic              illegal;
  logic              busy;

  modport master (
    output instr_valid, instr, dm_rdata, dm_ack,
    input  instr_ready, dm_req, dm_we, dm_addr, dm_wdata, retire, illegal, busy
  );

  modport slave (
    input  instr_valid, instr, dm_rdata, dm_ack,
    output instr_ready, dm_req, dm_we, dm_addr, dm_wdata, retire, illegal, busy
  );
endinterface

// File: rtl/riscv_multicycle_datapath.sv
// Multicycle RV64I-subset datapath (ADD, SUB, ADDI, LD, SD) with register file,
// IDLE/EX/MEM/WB sequencing and a req/ack data-memory port with wait states.
// Optional feature macro: RV_DATAPATH_SLT_EN adds SLT and SLTI.
module riscv_multicycle_datapath #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREG  = 32,
  parameter int unsigned DM_AW = 5
) (
  input logic CLK,
  input logic RST,
  riscv_multicycle_datapath_if.slave bus
);

  localparam int unsigned RW = $clog2(NREG);

  typedef enum logic [1:0] {S_IDLE, S_EX, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {OP_ILL, OP_ADD, OP_SUB, OP_ADDI, OP_LD, OP_SD, OP_SLT, OP_SLTI} op_t;

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] wd_q;
  logic            retire_q;
  logic [XLEN-1:0] rf [NREG];

  logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_s, op2, alu_res;
  op_t             op_ex;

  // Classify an instruction word; anything not recognised is illegal
  function automatic op_t decode(input logic [31:0] w);
    op_t op;
    op = OP_ILL;
    if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0000000)
      op = OP_ADD;
    else if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0100000)
      op = OP_SUB;
    else if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000)
      op = OP_ADDI;
    else if (w[6:0] == 7'b0000011 && w[14:12] == 3'b011)
      op = OP_LD;
    else if (w[6:0] == 7'b0100011 && w[14:12] == 3'b011)
      op = OP_SD;
`ifdef RV_DATAPATH_SLT_EN
    else if (w[6:0] == 7'b0110011 && w[14:12] == 3'b010 && w[31:25] == 7'b0000000)
      op = OP_SLT;
    else if (w[6:0] == 7'b0010011 && w[14:12] == 3'b010)
      op = OP_SLTI;
`endif
    return op;
  endfunction

  assign rs1_idx = ir[15 +: RW];
  assign rs2_idx = ir[20 +: RW];
  assign rd_idx  = ir[7 +: RW];

  // Operand fetch, immediate generation and ALU for the instruction in IR
  always_comb begin
    op_ex   = decode(ir);
    rs1_val = (rs1_idx == '0) ? '0 : rf[rs1_idx];
    rs2_val = (rs2_idx == '0) ? '0 : rf[rs2_idx];
    imm_i   = {{(XLEN-12){ir[31]}}, ir[31:20]};
    imm_s   = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    case (op_ex)
      OP_ADD, OP_SUB, OP_SLT: op2 = rs2_val;
      OP_SD:                  op2 = imm_s;
      default:                op2 = imm_i;
    endcase
    case (op_ex)
      OP_SUB:  alu_res = rs1_val - op2;
`ifdef RV_DATAPATH_SLT_EN
      OP_SLT, OP_SLTI:
               alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(op2))};
`endif
      default: alu_res = rs1_val + op2;
    endcase
  end

  // Sequencer, architectural state and registered port outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= S_IDLE;
      ir              <= '0;
      alu_q           <= '0;
      wd_q            <= '0;
      retire_q        <= 1'b0;
      bus.instr_ready <= 1'b1;
      bus.dm_req      <= 1'b0;
      bus.dm_we       <= 1'b0;
      bus.illegal     <= 1'b0;
      bus.busy        <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      retire_q    <= 1'b0;
      bus.illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            ir              <= bus.instr;
            state           <= S_EX;
            bus.instr_ready <= 1'b0;
            bus.busy        <= 1'b1;
            // flag illegal on capture so the pulse lines up with EX
            bus.illegal     <= (decode(bus.instr) == OP_ILL);
          end
        end
        S_EX: begin
          case (op_ex)
            OP_ILL: begin
              state           <= S_IDLE;
              bus.instr_ready <= 1'b1;
              bus.busy        <= 1'b0;
            end
            OP_LD, OP_SD: begin
              alu_q      <= alu_res;
              wd_q       <= rs2_val;
              state      <= S_MEM;
              bus.dm_req <= 1'b1;
              bus.dm_we  <= (op_ex == OP_SD);
            end
            default: begin
              alu_q    <= alu_res;
              wd_q     <= rs2_val;
              state    <= S_WB;
              retire_q <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (bus.dm_ack) begin
            bus.dm_req <= 1'b0;
            if (bus.dm_we) begin
              state           <= S_IDLE;
              bus.instr_ready <= 1'b1;
              bus.busy        <= 1'b0;
            end else begin
              alu_q    <= bus.dm_rdata;
              state    <= S_WB;
              retire_q <= 1'b1;
            end
          end
        end
        S_WB: begin
          if (rd_idx != '0) rf[rd_idx] <= alu_q;
          state           <= S_IDLE;
          bus.instr_ready <= 1'b1;
          bus.busy        <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dm_addr  = alu_q[DM_AW-1:0];
  assign bus.dm_wdata = wd_q;
  // A store completes in its ack cycle, so its retire cannot wait for a register stage
  assign bus.retire   = retire_q | ((state == S_MEM) && bus.dm_ack && bus.dm_we);

endmodule
